mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter between the data-side memory controller (Dmem_* bus) and the instruction-fetch controller (Imem_* bus), driving the single processor-to-memory port. It grants one request per cycle, returns the memory's accept tag to the granted requester only, and keeps a per-tag ownership table so each later load-data return (mem2proc_tag) reaches only the requester that issued it. Bus command encoding: 0 = BUS_NONE, 1 = BUS_LOAD, 2 = BUS_STORE. Response/tag encoding: 0 = none or reject, 1–15 = transaction tag.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive Imem losses before Imem is forced to win (range 1–15).

Ports:
- clock  in  1  system clock.
- reset  in  1  reset; asynchronous and active-high.
- Dmem_command  in  2  data-side command.
- Dmem_addr  in  16  data-side address.
- Dmem_size  in  2  data-side access size.
- Dmem_data  in  64  data-side store data.
- Imem_command  in  2  fetch-side command. Only BUS_NONE or BUS_LOAD is legal.
- Imem_addr  in  16  fetch-side address. Size is always double.
- mem2proc_response  in  4  memory accept tag for the current command.
- mem2proc_data  in  64  memory load data.
- mem2proc_tag  in  4  tag of the returning load data.
- proc2mem_command  out  2  granted command.
- proc2mem_addr  out  16  granted address.
- proc2mem_size  out  2  granted size.
- proc2mem_data  out  64  granted store data. 0 for Imem.
- Dmem_response  out  4  mem2proc_response if Dmem was granted, else 0.
- Dmem_tag  out  4  mem2proc_tag if the tag is owned by D, else 0.
- Dmem_rdata  out  64  mem2proc_data, passed through unconditionally.
- Imem_response  out  4  mem2proc_response if Imem was granted, else 0.
- Imem_tag  out  4  mem2proc_tag if the tag is owned by I, else 0.
- Imem_rdata  out  64  mem2proc_data, passed through unconditionally.
- arb_err  out  1  sticky flag: a nonzero return tag had no owner.

## Operation
Grant (combinational):
- Only Dmem requests: Dmem wins. Only Imem requests: Imem wins. Neither: proc2mem_command = BUS_NONE.
- Both request: Dmem wins, except when fairness forces Imem (see Configuration).
- The losing requester sees response 0. This is the codebase's existing "can't accept, retry" semantics, so requesters hold their command and retry.

Ownership table:
- 15 entries, indexed by tag 1–15. Each entry holds valid + owner (D/I).
- Allocate on a granted BUS_LOAD with mem2proc_response != 0: entry[response] ← {valid, owner}.
- Stores never allocate.

Routing:
- A nonzero mem2proc_tag is routed using the table state before this cycle's update. The matching entry is cleared at the clock edge.
- Nonzero mem2proc_tag whose entry is invalid: both *_tag outputs are 0 and arb_err sets. arb_err clears only on reset.

Simultaneous events:
- A tag returning and the same tag being reallocated in one cycle: the allocation wins, so the entry ends valid with the new owner.

## Timing
- Grant and the response/tag/data paths are zero-latency combinational. The table and starve counter update on posedge clock.
- While reset is asserted, outputs are: proc2mem_command = BUS_NONE, proc2mem_addr/size/data = 0, both *_response = 0, both *_tag = 0. Both *_rdata follow mem2proc_data.
- Reset (asynchronous, including mid-operation) produces: table all invalid, starve counter 0, arb_err 0.
- After reset, tags still outstanding are dropped when they return, and arb_err sets.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - A 4-bit starve counter increments each cycle both sides request and Dmem wins.
  - When the counter equals STARVE_LIMIT, Imem wins that cycle's contention.
  - The counter resets to 0 when Imem is accepted (response != 0) or Imem is idle.
  - If Imem is granted but rejected, the counter holds at STARVE_LIMIT, so Imem keeps priority.
- MEM_ARB_FAIR_EN undefined: fixed Dmem priority; no counter is built.

## Test plan
- Dmem BUS_LOAD addr 0x0040, mem response 3 → proc2mem_command 1 with addr 0x0040. Dmem_response 3, Imem_response 0. Later mem2proc_tag 3 → Dmem_tag 3, Imem_tag 0, entry 3 cleared.
- Dmem and Imem both request BUS_LOAD, memory always responds 5, STARVE_LIMIT 4, FAIR_EN defined → Dmem is granted for cycles 0–3 and Imem for cycle 4. Without the macro, Imem is never granted.
- Dmem BUS_STORE with data 0xDEADBEEF, response 7 → Dmem_response 7, no table allocation. A later tag 7 return → both tags 0, arb_err 1.
- Tag 2 returns for I in the same cycle Dmem's new load is accepted with response 2 → Imem_tag 2 this cycle; entry 2 is owned by D next cycle.
- Imem granted with mem response 0 under FAIR_EN at the limit → Imem_response 0, counter holds, Imem wins again the next cycle.
- Assert reset with tags 4 (D) and 9 (I) outstanding → all outputs go to their reset values. Tag 9 returning afterwards → Imem_tag 0, arb_err 1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the memory port and mem_arbiter.
// slave  : the arbiter's view (requests and memory returns in, grants out).
// master : the surrounding system's view (requesters + memory model).
interface mem_arbiter_if;
    logic [1:0]  Dmem_command;
    logic [15:0] Dmem_addr;
    logic [1:0]  Dmem_size;
    logic [63:0] Dmem_data;
    logic [1:0]  Imem_command;
    logic [15:0] Imem_addr;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic [1:0]  proc2mem_command;
    logic [15:0] proc2mem_addr;
    logic [1:0]  proc2mem_size;
    logic [63:0] proc2mem_data;
    logic [3:0]  Dmem_response;
    logic [3:0]  Dmem_tag;
    logic [63:0] Dmem_rdata;
    logic [3:0]  Imem_response;
    logic [3:0]  Imem_tag;
    logic [63:0] Imem_rdata;
    logic        arb_err;

    modport slave (
        input  Dmem_command, Dmem_addr, Dmem_size, Dmem_data,
        input  Imem_command, Imem_addr,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_size, proc2mem_data,
        output Dmem_response, Dmem_tag, Dmem_rdata,
        output Imem_response, Imem_tag, Imem_rdata,
        output arb_err
    );

    modport master (
        output Dmem_command, Dmem_addr, Dmem_size, Dmem_data,
        output Imem_command, Imem_addr,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_size, proc2mem_data,
        input  Dmem_response, Dmem_tag, Dmem_rdata,
        input  Imem_response, Imem_tag, Imem_rdata,
        input  arb_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: Dmem vs Imem onto one processor-to-memory port,
// with a per-tag ownership table steering load-data returns back to the
// requester that issued them.
// Optional feature macro: MEM_ARB_FAIR_EN (starvation counter that forces
// Imem to win after STARVE_LIMIT consecutive contention losses).
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    localparam logic [1:0] SIZE_DOUBLE = 2'd3;

    logic        d_req, i_req;
    logic        force_i;
    logic        grant_d, grant_i;
    logic        alloc;
    logic [15:0] tbl_valid;
    logic [15:0] tbl_own_i;
    logic        ret_nz, ret_hit, orphan;
    logic        err_q;

    // Request decode and grant selection
    always_comb begin
        d_req   = (bus.Dmem_command != BUS_NONE);
        i_req   = (bus.Imem_command != BUS_NONE);
        grant_i = i_req && (!d_req || force_i);
        grant_d = d_req && !grant_i;
    end

`ifdef MEM_ARB_FAIR_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    always_comb force_i = (starve_cnt == LIMIT);

    // Starvation counter: counts Dmem wins under contention; a granted but
    // rejected Imem leaves it at LIMIT so Imem keeps priority on retry
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!i_req || (grant_i && (bus.mem2proc_response != 4'd0))) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    always_comb force_i = 1'b0;
`endif

    // Granted command onto the memory port and accept-tag steering
    always_comb begin
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_size    = '0;
        bus.proc2mem_data    = '0;
        bus.Dmem_response    = '0;
        bus.Imem_response    = '0;
        if (!reset) begin
            if (grant_d) begin
                bus.proc2mem_command = bus.Dmem_command;
                bus.proc2mem_addr    = bus.Dmem_addr;
                bus.proc2mem_size    = bus.Dmem_size;
                bus.proc2mem_data    = bus.Dmem_data;
                bus.Dmem_response    = bus.mem2proc_response;
            end else if (grant_i) begin
                bus.proc2mem_command = bus.Imem_command;
                bus.proc2mem_addr    = bus.Imem_addr;
                bus.proc2mem_size    = SIZE_DOUBLE;
                bus.Imem_response    = bus.mem2proc_response;
            end
        end
    end

    // Return-tag routing from the table contents before this cycle's update
    always_comb begin
        ret_nz         = (bus.mem2proc_tag != 4'd0);
        ret_hit        = ret_nz && tbl_valid[bus.mem2proc_tag];
        orphan         = ret_nz && !tbl_valid[bus.mem2proc_tag];
        alloc          = (bus.proc2mem_command == BUS_LOAD) && (bus.mem2proc_response != 4'd0);
        bus.Dmem_tag   = '0;
        bus.Imem_tag   = '0;
        bus.Dmem_rdata = bus.mem2proc_data;
        bus.Imem_rdata = bus.mem2proc_data;
        bus.arb_err    = err_q;
        if (!reset && ret_hit) begin
            if (tbl_own_i[bus.mem2proc_tag]) bus.Imem_tag = bus.mem2proc_tag;
            else                             bus.Dmem_tag = bus.mem2proc_tag;
        end
    end

    // Ownership table and sticky orphan flag; the allocation write comes
    // after the return clear so a same-tag reallocation wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tbl_valid <= '0;
            tbl_own_i <= '0;
            err_q     <= 1'b0;
        end else begin
            if (ret_nz) tbl_valid[bus.mem2proc_tag] <= 1'b0;
            if (alloc) begin
                tbl_valid[bus.mem2proc_response] <= 1'b1;
                tbl_own_i[bus.mem2proc_response] <= grant_i;
            end
            if (orphan) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int unsigned LIMIT = 4;

    logic clock = 1'b0;
    logic reset;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference state: who issued each outstanding tag (0 free, 1 D, 2 I),
    // Imem's current losing streak, and the sticky orphan flag.
    int owner_tbl[16];
    int losses = 0;
    bit err_flag = 1'b0;

`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] dc, input logic [15:0] da, input logic [1:0] ds,
                         input logic [63:0] dd, input logic [1:0] ic, input logic [15:0] ia,
                         input logic [3:0] rsp, input logic [3:0] tag);
        bus.Dmem_command      = dc;
        bus.Dmem_addr         = da;
        bus.Dmem_size         = ds;
        bus.Dmem_data         = dd;
        bus.Imem_command      = ic;
        bus.Imem_addr         = ia;
        bus.mem2proc_response = rsp;
        bus.mem2proc_tag      = tag;
        bus.mem2proc_data     = {$urandom, $urandom};
    endtask

    // Called at posedge+1 with inputs applied: checks at the falling edge,
    // then advances the model across the next rising edge. Returns the winner.
    task automatic step(output int winner);
        int win, tag, rsp, edt, eit;
        bit dreq, ireq, orph;
        logic [1:0] ecmd, esize;
        logic [15:0] eaddr;
        logic [63:0] edata;
        logic [3:0] edr, eir;
        #4;
        dreq = (bus.Dmem_command != 2'd0);
        ireq = (bus.Imem_command != 2'd0);
        tag  = int'(bus.mem2proc_tag);
        rsp  = int'(bus.mem2proc_response);
        win  = 0;
        if (dreq && ireq) win = (FAIR && losses >= int'(LIMIT)) ? 2 : 1;
        else if (dreq)    win = 1;
        else if (ireq)    win = 2;
        if (reset) begin
            win      = 0;
            err_flag = 1'b0;
        end
        ecmd = 2'd0; eaddr = 16'd0; esize = 2'd0; edata = 64'd0; edr = 4'd0; eir = 4'd0;
        if (win == 1) begin
            ecmd = bus.Dmem_command; eaddr = bus.Dmem_addr; esize = bus.Dmem_size;
            edata = bus.Dmem_data; edr = bus.mem2proc_response;
        end else if (win == 2) begin
            ecmd = bus.Imem_command; eaddr = bus.Imem_addr; esize = 2'd3;
            eir = bus.mem2proc_response;
        end
        edt = 0; eit = 0; orph = 1'b0;
        if (tag != 0 && !reset) begin
            if (owner_tbl[tag] == 1)      edt = tag;
            else if (owner_tbl[tag] == 2) eit = tag;
            else                          orph = 1'b1;
        end
        chk("cmd",    64'(bus.proc2mem_command), 64'(ecmd));
        chk("addr",   64'(bus.proc2mem_addr),    64'(eaddr));
        chk("size",   64'(bus.proc2mem_size),    64'(esize));
        chk("data",   bus.proc2mem_data,         edata);
        chk("d_resp", 64'(bus.Dmem_response),    64'(edr));
        chk("i_resp", 64'(bus.Imem_response),    64'(eir));
        chk("d_tag",  64'(bus.Dmem_tag),         64'(edt));
        chk("i_tag",  64'(bus.Imem_tag),         64'(eit));
        chk("d_rdata", bus.Dmem_rdata,           bus.mem2proc_data);
        chk("i_rdata", bus.Imem_rdata,           bus.mem2proc_data);
        chk("arb_err", 64'(bus.arb_err),         64'(err_flag));
        @(posedge clock);
        if (reset) begin
            foreach (owner_tbl[i]) owner_tbl[i] = 0;
            losses   = 0;
            err_flag = 1'b0;
        end else begin
            if (tag != 0) owner_tbl[tag] = 0;
            if (win != 0 && ecmd == 2'd1 && rsp != 0) owner_tbl[rsp] = win;
            if (orph) err_flag = 1'b1;
            if (!ireq)                    losses = 0;
            else if (win == 2 && rsp != 0) losses = 0;
            else if (win == 1)            losses++;
        end
        #1;
        winner = win;
    endtask

    task automatic idle();
        drive(2'd0, 16'd0, 2'd0, 64'd0, 2'd0, 16'd0, 4'd0, 4'd0);
    endtask

    initial begin
        int w;
        int outstanding[$];
        foreach (owner_tbl[i]) owner_tbl[i] = 0;
        reset = 1'b1;
        idle();
        @(posedge clock);
        #1;

        // Reset state
        step(w);
        reset = 1'b0;

        // Dmem load accepted with tag 3, later returned to Dmem only
        drive(2'd1, 16'h0040, 2'd3, 64'd0, 2'd0, 16'd0, 4'd3, 4'd0);
        step(w);
        chk("dload_winner", 64'(w), 64'd1);
        idle(); bus.mem2proc_tag = 4'd3;
        step(w);
        idle(); bus.mem2proc_tag = 4'd3;   // entry now free: orphan
        step(w);
        idle();
        step(w);
        chk("orphan_sticky", 64'(bus.arb_err), 64'd1);
        reset = 1'b1; idle(); step(w); reset = 1'b0;

        // Contention with the memory always accepting tag 5
        for (int c = 0; c < 6; c++) begin
            drive(2'd1, 16'h1000, 2'd3, 64'h1111, 2'd1, 16'h2000, 4'd5, 4'd0);
            step(w);
            chk("contend_winner", 64'(w), (FAIR && c == 4) ? 64'd2 : 64'd1);
        end

        // Store does not allocate; returning its tag is an orphan
        drive(2'd2, 16'h0080, 2'd2, 64'h00000000DEADBEEF, 2'd0, 16'd0, 4'd7, 4'd0);
        step(w);
        idle(); bus.mem2proc_tag = 4'd7;
        step(w);
        idle();
        step(w);
        reset = 1'b1; idle(); step(w); reset = 1'b0;

        // Same-tag return (I) and reallocation (D) in one cycle
        drive(2'd0, 16'd0, 2'd0, 64'd0, 2'd1, 16'h0300, 4'd2, 4'd0);
        step(w);
        drive(2'd1, 16'h0400, 2'd3, 64'd0, 2'd0, 16'd0, 4'd2, 4'd2);
        step(w);
        idle(); bus.mem2proc_tag = 4'd2;
        step(w);

        // Contention with the memory rejecting everything
        for (int c = 0; c < 7; c++) begin
            drive(2'd1, 16'h5000, 2'd3, 64'h2222, 2'd1, 16'h6000, 4'd0, 4'd0);
            step(w);
            chk("reject_winner", 64'(w), (FAIR && c >= 4) ? 64'd2 : 64'd1);
        end

        // Reset with tags 4 (D) and 9 (I) outstanding
        idle(); step(w);
        drive(2'd1, 16'h0700, 2'd3, 64'd0, 2'd0, 16'd0, 4'd4, 4'd0);
        step(w);
        drive(2'd0, 16'd0, 2'd0, 64'd0, 2'd1, 16'h0800, 4'd9, 4'd0);
        step(w);
        reset = 1'b1;
        drive(2'd1, 16'h0900, 2'd3, 64'h33, 2'd1, 16'h0a00, 4'd6, 4'd9);
        step(w);
        reset = 1'b0;
        idle(); bus.mem2proc_tag = 4'd9;
        step(w);
        idle();
        step(w);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [3:0] rsp, tag;
            outstanding.delete();
            for (int t = 1; t < 16; t++) if (owner_tbl[t] != 0) outstanding.push_back(t);
            rsp = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if (outstanding.size() > 0 && $urandom_range(0, 1) == 1)
                tag = 4'(outstanding[$urandom_range(0, outstanding.size() - 1)]);
            else if ($urandom_range(0, 3) == 0)
                tag = 4'($urandom_range(1, 15));
            else
                tag = 4'd0;
            drive(2'($urandom_range(0, 2)), 16'($urandom), 2'($urandom_range(0, 3)),
                  {$urandom, $urandom}, 2'($urandom_range(0, 1)), 16'($urandom), rsp, tag);
            reset = ($urandom_range(0, 59) == 0);
            step(w);
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
